// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: program counter, bundle request issue and bundle FIFO
// sitting directly in front of instruction_fetch.
// Optional feature macro: FETCH_PERF_CNT_EN adds the perf_bundles and
// perf_stall counters. The default build leaves that macro undefined.
module fetch_pc_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [127:0] imem_rsp_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         bundle_valid,
  input  logic         bundle_ready,
  output logic [127:0] bundle_data,
  output logic [31:0]  bundle_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_bundles,
  output logic [31:0]  perf_stall
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [127:0]     fifo_data_q [DEPTH];
  logic [127:0]     fifo_data_d [DEPTH];
  logic [31:0]      fifo_pc_q [DEPTH];
  logic [31:0]      fifo_pc_d [DEPTH];
  logic [31:0]      tag_pc_q [DEPTH];
  logic [31:0]      tag_pc_d [DEPTH];

  logic [CNT_W:0]   credit_sum;
  logic             accept;
  logic             rsp_take;
  logic             push;
  logic             pop;

  // Handshakes: request credit, response acceptance and FIFO head presentation.
  always_comb begin
    credit_sum     = {1'b0, count_q} + {1'b0, outst_q};
    imem_req_valid = !rst && !redirect_valid && (credit_sum < DEPTH_C);
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (outst_q != '0);
    bundle_valid   = (count_q != '0);
    bundle_data    = bundle_valid ? fifo_data_q[rd_ptr_q] : '0;
    bundle_pc      = bundle_valid ? fifo_pc_q[rd_ptr_q] : '0;
    pop            = bundle_valid && bundle_ready && !redirect_valid;
    push           = rsp_take && (drop_q == '0) && !redirect_valid;
  end

  // Next state: PC advance, tag queue, in-flight and drop bookkeeping, FIFO; redirect overrides.
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    tag_rd_d    = tag_rd_q;
    tag_wr_d    = tag_wr_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    tag_pc_d    = tag_pc_q;

    if (accept) begin
      tag_pc_d[tag_wr_q] = pc_q;
      tag_wr_d           = tag_wr_q + PTR_W'(1);
      pc_d               = pc_q + 32'd16;
    end

    if (rsp_take) begin
      tag_rd_d = tag_rd_q + PTR_W'(1);
      if (drop_q != '0) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end

    case ({accept, rsp_take})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = imem_rsp_data;
      fifo_pc_d[wr_ptr_q]   = tag_pc_q[tag_rd_q];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:4], 4'b0000};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = outst_q - CNT_W'(rsp_take);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Storage arrays need no reset: the outputs are gated by the FIFO count.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_pc_q   <= fifo_pc_d;
    tag_pc_q    <= tag_pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bundles_q, perf_bundles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count delivered bundles and cycles where downstream waits on an empty FIFO.
  always_comb begin
    perf_bundles_d = perf_bundles_q + (pop ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q + ((bundle_ready && !bundle_valid) ? 32'd1 : 32'd0);
  end

  // Performance counter registers, cleared by reset and wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bundles_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_bundles_q <= perf_bundles_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_bundles = perf_bundles_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_pc_queue.sv
// tb_fetch_pc_queue: randomized and directed bench for fetch_pc_queue with an
// in-order memory model and a transaction-level reference model.
module tb_fetch_pc_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [127:0] imem_rsp_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         bundle_valid;
  logic         bundle_ready;
  logic [127:0] bundle_data;
  logic [31:0]  bundle_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  perf_bundles;
  logic [31:0]  perf_stall;
`endif

  fetch_pc_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
    .bundle_data(bundle_data), .bundle_pc(bundle_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_bundles(perf_bundles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // In-flight request: address, cycle its response is due, and whether a redirect made it stale.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } infl_t;

  typedef struct {
    logic [31:0]  pc;
    logic [127:0] data;
  } ent_t;

  infl_t infl[$];
  ent_t  mfifo[$];
  logic [31:0] mpc;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [31:0] mperf_b = '0;
  logic [31:0] mperf_s = '0;

  bit          cfg_rst, cfg_ready, cfg_bready, cfg_redir;
  logic [31:0] cfg_rpc;
  int          cfg_lat;
  bit          m_req_valid;
  bit          m_rsp;

  function automatic logic [127:0] bundleOf(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a + 32'h3, a};
  endfunction

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive this cycle's inputs at the falling edge; the memory answers its oldest due request.
  task automatic applyStimulus();
    @(negedge clk);
    rst            = cfg_rst;
    imem_req_ready = cfg_ready;
    bundle_ready   = cfg_bready;
    redirect_valid = cfg_redir;
    redirect_pc    = cfg_rpc;
    m_rsp = !cfg_rst && (infl.size() > 0) && (infl[0].due <= cyc);
    imem_rsp_valid = m_rsp;
    imem_rsp_data  = m_rsp ? bundleOf(infl[0].addr) : {$urandom(), $urandom(), $urandom(), $urandom()};
    m_req_valid = !cfg_rst && !cfg_redir && (mfifo.size() + infl.size() < DEPTH);
    #1;
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput();
    checkVal("req_valid", imem_req_valid, m_req_valid);
    checkVal("req_addr", imem_req_addr, mpc);
    checkVal("bundle_valid", bundle_valid, mfifo.size() > 0);
    if (mfifo.size() > 0) begin
      checkVal("bundle_data", bundle_data, mfifo[0].data);
      checkVal("bundle_pc", bundle_pc, mfifo[0].pc);
    end
`ifdef FETCH_PERF_CNT_EN
    checkVal("perf_bundles", perf_bundles, mperf_b);
    checkVal("perf_stall", perf_stall, mperf_s);
`endif
  endtask

  task automatic advance();
    infl_t e;
    bit acc;
    bit pop;
    int lat;
    @(posedge clk);
    if (cfg_rst) begin
      mpc = RST_PC;
      infl.delete();
      mfifo.delete();
      mperf_b = '0;
      mperf_s = '0;
    end else begin
      acc = m_req_valid && cfg_ready;
      pop = (mfifo.size() > 0) && cfg_bready;
      if (pop && !cfg_redir) mperf_b = mperf_b + 32'd1;
      if (cfg_bready && mfifo.size() == 0) mperf_s = mperf_s + 32'd1;
      if (m_rsp) e = infl.pop_front();
      if (cfg_redir) begin
        mfifo.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
        mpc = {cfg_rpc[31:4], 4'b0000};
      end else begin
        if (pop) void'(mfifo.pop_front());
        if (m_rsp && !e.stale) mfifo.push_back('{pc: e.addr, data: bundleOf(e.addr)});
      end
      if (acc) begin
        lat = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 4));
        infl.push_back('{addr: mpc, due: cyc + lat, stale: 1'b0});
        mpc = mpc + 32'd16;
      end
    end
    cyc++;
  endtask

  task automatic doReset(input bit pin);
    cfg_rst = 1'b1;
    cfg_redir = 1'b0;
    applyStimulus();
    advance();
    applyStimulus();
    checkOutput();
    if (pin) begin
      checkVal("rst_req_valid", imem_req_valid, 1'b0);
      checkVal("rst_req_addr", imem_req_addr, 32'h0000_0100);
      checkVal("rst_bundle_valid", bundle_valid, 1'b0);
      checkVal("rst_bundle_data", bundle_data, 128'h0);
      checkVal("rst_bundle_pc", bundle_pc, 32'h0);
    end
    advance();
    cfg_rst = 1'b0;
  endtask

  initial begin
    int accepts;
    bit found;
    cfg_rst = 1'b1; cfg_ready = 1'b1; cfg_bready = 1'b1; cfg_redir = 1'b0;
    cfg_rpc = '0; cfg_lat = 1;
    mpc = RST_PC;

    // Streaming with a one-cycle memory: sequential addresses, first bundle two cycles after accept.
    doReset(1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput();
      checkVal("s1_addr", imem_req_addr, 32'h100 + 32'(16 * i));
      if (i < 2) checkVal("s1_no_bundle", bundle_valid, 1'b0);
      else begin
        checkVal("s1_bundle_valid", bundle_valid, 1'b1);
        checkVal("s1_bundle_pc", bundle_pc, 32'h100 + 32'(16 * (i - 2)));
      end
      if (i == 2) checkVal("s1_bundle_lo", bundle_data[31:0], 32'h100);
      advance();
    end

    // Downstream stalled: credits stop issue at four, then four bundles drain in order.
    doReset(1'b0);
    cfg_bready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput();
      if (imem_req_valid && imem_req_ready) accepts++;
      advance();
    end
    checkVal("s2_accepts", accepts, 4);
    applyStimulus();
    checkOutput();
    checkVal("s2_req_blocked", imem_req_valid, 1'b0);
    advance();
    cfg_bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput();
      checkVal("s2_drain_valid", bundle_valid, 1'b1);
      checkVal("s2_drain_pc", bundle_pc, 32'h100 + 32'(16 * i));
      advance();
    end

    // Redirect with three requests in flight: stale responses vanish, first bundle is the target.
    doReset(1'b0);
    cfg_lat = 4;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(); checkOutput(); advance();
    end
    cfg_redir = 1'b1; cfg_rpc = 32'h0000_2000;
    applyStimulus(); checkOutput();
    checkVal("s3_no_req_on_redirect", imem_req_valid, 1'b0);
    advance();
    cfg_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(); checkOutput();
      if (i == 0) checkVal("s3_new_addr", imem_req_addr, 32'h0000_2000);
      if (bundle_valid) begin
        checkVal("s3_first_pc", bundle_pc, 32'h0000_2000);
        found = 1'b1;
      end
      advance();
    end
    if (!found) checkVal("s3_bundle_timeout", 1'b0, 1'b1);

    // Misaligned redirect target has its low bits cleared.
    cfg_redir = 1'b1; cfg_rpc = 32'h0000_200C;
    applyStimulus(); checkOutput(); advance();
    cfg_redir = 1'b0;
    applyStimulus(); checkOutput();
    checkVal("s4_aligned_addr", imem_req_addr, 32'h0000_2000);
    advance();

    // Redirect coinciding with a response while two are outstanding: only one is dropped afterwards.
    doReset(1'b0);
    cfg_lat = 2;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(); checkOutput(); advance();
    end
    cfg_redir = 1'b1; cfg_rpc = 32'h0000_3000;
    applyStimulus(); checkOutput();
    checkVal("s5_rsp_with_redirect", imem_rsp_valid, 1'b1);
    advance();
    cfg_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(); checkOutput();
      if (bundle_valid) begin
        checkVal("s5_first_pc", bundle_pc, 32'h0000_3000);
        found = 1'b1;
      end
      advance();
    end
    if (!found) checkVal("s5_bundle_timeout", 1'b0, 1'b1);

    // Random traffic: variable latency, backpressure, redirects and occasional resets.
    cfg_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      cfg_rst    = ($urandom_range(0, 199) == 0);
      cfg_ready  = ($urandom_range(0, 3) != 0);
      cfg_bready = ($urandom_range(0, 2) != 0);
      cfg_redir  = ($urandom_range(0, 19) == 0);
      cfg_rpc    = $urandom();
      applyStimulus();
      checkOutput();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
